// File: rtl/vending_machine_change.sv
// Coin-credit vending controller: N_ITEMS individually priced products, change paid out in CHG_UNIT coins.
// Coin->credit 2 edges, select->dispense 3 edges; change stalls indefinitely on chg_rdy, coins outside IDLE are rejected.

module vending_machine_change #(
   parameter int W        = 8,
   parameter int N_ITEMS  = 4,
   parameter int CHG_UNIT = 5,
   localparam int IW      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 c,
   input  logic [W-1:0]         a,
   input  logic                 sel_v,
   input  logic [IW-1:0]        sel,
   input  logic                 cancel,
   input  logic [N_ITEMS*W-1:0] prices,
   input  logic                 chg_rdy,
   output logic                 d,
   output logic [IW-1:0]        d_item,
   output logic                 chg_v,
   output logic                 coin_rej,
   output logic                 short,
   output logic                 sel_err,
   output logic                 busy,
   output logic [W-1:0]         tot
);

   localparam logic [W-1:0] UNIT = W'(CHG_UNIT);

   typedef enum logic [2:0] {IDLE, ADD, CHECK, DISP, CHANGE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  tot_nxt;
   logic [W-1:0]  coin_q, coin_nxt;
   logic [IW-1:0] sel_q, sel_nxt;
   logic [W-1:0]  price_q, price_nxt;
   logic [W-1:0]  sel_price;
   logic [W:0]    sum;
   logic [W-1:0]  diff;
   logic [W-1:0]  after_unit;
   logic          d_nxt, rej_nxt, short_nxt, sel_err_nxt;
   logic [IW-1:0] d_item_nxt;

   // Out-of-range indices match no entry and read as price 0, i.e. disabled.
   always_comb begin
      sel_price = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (sel_q == IW'(i)) sel_price = prices[i*W +: W];
      end
   end

   assign sum        = {1'b0, tot} + {1'b0, coin_q};
   assign diff       = tot - price_q;
   assign after_unit = tot - UNIT;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      tot_nxt     = tot;
      coin_nxt    = coin_q;
      sel_nxt     = sel_q;
      price_nxt   = price_q;
      d_nxt       = 1'b0;
      d_item_nxt  = '0;
      rej_nxt     = 1'b0;
      short_nxt   = 1'b0;
      sel_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (c) begin
               coin_nxt  = a;
               state_nxt = ADD;
            end else if (cancel) begin
               if (tot >= UNIT) state_nxt = CHANGE;
            end else if (sel_v) begin
               sel_nxt   = sel;
               state_nxt = CHECK;
            end
         end
         ADD: begin
            if (sum[W]) rej_nxt = 1'b1;
            else        tot_nxt = sum[W-1:0];
            state_nxt = IDLE;
         end
         CHECK: begin
            price_nxt = sel_price;
            if (sel_price == '0) begin
               sel_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end else if (tot < sel_price) begin
               short_nxt = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = DISP;
            end
         end
         DISP: begin
            d_nxt      = 1'b1;
            d_item_nxt = sel_q;
            tot_nxt    = diff;
            state_nxt  = (diff >= UNIT) ? CHANGE : IDLE;
         end
         CHANGE: begin
            if (tot >= UNIT) begin
               if (chg_rdy) begin
                  tot_nxt = after_unit;
                  if (after_unit < UNIT) state_nxt = IDLE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (c && (state != IDLE)) rej_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tot      <= '0;
         coin_q   <= '0;
         sel_q    <= '0;
         price_q  <= '0;
         d        <= 1'b0;
         d_item   <= '0;
         coin_rej <= 1'b0;
         short    <= 1'b0;
         sel_err  <= 1'b0;
      end else begin
         tot      <= tot_nxt;
         coin_q   <= coin_nxt;
         sel_q    <= sel_nxt;
         price_q  <= price_nxt;
         d        <= d_nxt;
         d_item   <= d_item_nxt;
         coin_rej <= rej_nxt;
         short    <= short_nxt;
         sel_err  <= sel_err_nxt;
      end
   end

   assign chg_v = (state == CHANGE) && (tot >= UNIT);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: directed scenarios plus randomized operations against a
// transaction-level credit model (coin, select, cancel outcomes computed with plain arithmetic).

module tb_vending_machine_change;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int U  = 5;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          nrst, c, sel_v, cancel, chg_rdy;
   logic [W-1:0]  a;
   logic [IW-1:0] sel;
   logic [N*W-1:0] prices;
   logic          d, chg_v, coin_rej, shrt, sel_err, busy;
   logic [IW-1:0] d_item;
   logic [W-1:0]  tot;

   vending_machine_change #(.W(W), .N_ITEMS(N), .CHG_UNIT(U)) dut (
      .clk(clk), .nrst(nrst), .c(c), .a(a), .sel_v(sel_v), .sel(sel), .cancel(cancel),
      .prices(prices), .chg_rdy(chg_rdy), .d(d), .d_item(d_item), .chg_v(chg_v),
      .coin_rej(coin_rej), .short(shrt), .sel_err(sel_err), .busy(busy), .tot(tot)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_d = 0, n_rej = 0, n_short = 0, n_selerr = 0, n_xfer = 0;
   logic [IW-1:0] last_item = '0;
   int s_d, s_rej, s_short, s_selerr, s_xfer;
   int m_tot;
   int price_tab [N];

   // Inputs change 1 time unit after posedge, so the negedge sees a settled cycle.
   always @(negedge clk) begin
      if (d) begin
         n_d++;
         last_item = d_item;
      end
      if (coin_rej) n_rej++;
      if (shrt) n_short++;
      if (sel_err) n_selerr++;
      if (chg_v && chg_rdy) n_xfer++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_d = n_d; s_rej = n_rej; s_short = n_short; s_selerr = n_selerr; s_xfer = n_xfer;
   endtask

   task automatic set_prices();
      for (int i = 0; i < N; i++) begin
         int p;
         p = price_tab[i];
         prices[i*W +: W] = p[W-1:0];
      end
   endtask

   task automatic wait_idle(input bit rnd);
      int k;
      k = 0;
      while (busy && k < 400) begin
         if (rnd) chg_rdy = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
      end
      repeat (2) tick();
   endtask

   task automatic coin(input int v);
      c = 1'b1;
      a = v[W-1:0];
      tick();
      c = 1'b0;
      a = '0;
      wait_idle(1'b0);
   endtask

   task automatic select(input int i, input bit rnd);
      sel_v = 1'b1;
      sel = i[IW-1:0];
      tick();
      sel_v = 1'b0;
      wait_idle(rnd);
   endtask

   task automatic cancel_req(input bit rnd);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      wait_idle(rnd);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({d, d_item, chg_v, coin_rej, shrt, sel_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: d=%b item=%0d chg_v=%b rej=%b short=%b sel_err=%b busy=%b, required all 0",
                  d, d_item, chg_v, coin_rej, shrt, sel_err, busy);
      end
      checks++;
      if (tot !== 8'd0) begin
         errors++;
         $display("FAIL reset_tot: got %0d required 0", tot);
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      m_tot = 0;
      tick();
   endtask

   task automatic test_purchase();
      c = 1'b1;
      a = 8'd10;
      tick();
      c = 1'b0;
      checks++;
      if (tot !== 8'd0) begin
         errors++;
         $display("FAIL coin_latency_edge1: tot=%0d required 0", tot);
      end
      tick();
      checks++;
      if (tot !== 8'd10) begin
         errors++;
         $display("FAIL coin_latency_edge2: tot=%0d required 10", tot);
      end
      tick();
      coin(10);
      coin(10);
      checks++;
      if (tot !== 8'd30) begin
         errors++;
         $display("FAIL purchase_credit: tot=%0d required 30", tot);
      end
      snap();
      chg_rdy = 1'b1;
      sel_v = 1'b1;
      sel = 2'd0;
      tick();
      sel_v = 1'b0;
      tick();
      checks++;
      if (d !== 1'b0) begin
         errors++;
         $display("FAIL dispense_early: d=%b after 2 edges, required 0", d);
      end
      tick();
      checks++;
      if (d !== 1'b1 || d_item !== 2'd0 || tot !== 8'd5 || chg_v !== 1'b1) begin
         errors++;
         $display("FAIL dispense_edge3: d=%b item=%0d tot=%0d chg_v=%b, required 1/0/5/1",
                  d, d_item, tot, chg_v);
      end
      tick();
      checks++;
      if (tot !== 8'd0 || busy !== 1'b0 || chg_v !== 1'b0) begin
         errors++;
         $display("FAIL purchase_change: tot=%0d busy=%b chg_v=%b, required 0/0/0", tot, busy, chg_v);
      end
      tick();
      checks++;
      if (n_d - s_d !== 1 || n_xfer - s_xfer !== 1) begin
         errors++;
         $display("FAIL purchase_counts: d pulses=%0d transfers=%0d, required 1/1", n_d - s_d, n_xfer - s_xfer);
      end
      m_tot = 0;
   endtask

   task automatic test_short();
      coin(10); coin(10); coin(10);
      snap();
      select(1, 1'b0);
      checks++;
      if (n_short - s_short !== 1 || n_d - s_d !== 0 || tot !== 8'd30 || busy !== 1'b0) begin
         errors++;
         $display("FAIL short_credit: short=%0d d=%0d tot=%0d busy=%b, required 1/0/30/0",
                  n_short - s_short, n_d - s_d, tot, busy);
      end
      m_tot = 30;
   endtask

   task automatic test_overflow();
      coin(220);
      checks++;
      if (tot !== 8'd250) begin
         errors++;
         $display("FAIL overflow_setup: tot=%0d required 250", tot);
      end
      snap();
      coin(10);
      checks++;
      if (n_rej - s_rej !== 1 || tot !== 8'd250) begin
         errors++;
         $display("FAIL overflow_reject: rej=%0d tot=%0d, required 1/250", n_rej - s_rej, tot);
      end
      snap();
      coin(5);
      checks++;
      if (n_rej - s_rej !== 0 || tot !== 8'd255) begin
         errors++;
         $display("FAIL overflow_max: rej=%0d tot=%0d, required 0/255", n_rej - s_rej, tot);
      end
      snap();
      select(3, 1'b0);
      checks++;
      if (n_d - s_d !== 1 || last_item !== 2'd3 || tot !== 8'd0 || n_xfer - s_xfer !== 0) begin
         errors++;
         $display("FAIL buy_item3: d=%0d item=%0d tot=%0d xfer=%0d, required 1/3/0/0",
                  n_d - s_d, last_item, tot, n_xfer - s_xfer);
      end
      m_tot = 0;
   endtask

   task automatic test_stall_cancel();
      coin(13);
      snap();
      chg_rdy = 1'b0;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      checks++;
      if (chg_v !== 1'b1 || tot !== 8'd13) begin
         errors++;
         $display("FAIL stall_cycle1: chg_v=%b tot=%0d, required 1/13", chg_v, tot);
      end
      c = 1'b1;
      a = 8'd50;
      tick();
      c = 1'b0;
      a = '0;
      checks++;
      if (chg_v !== 1'b1 || tot !== 8'd13) begin
         errors++;
         $display("FAIL stall_cycle2: chg_v=%b tot=%0d, required 1/13", chg_v, tot);
      end
      chg_rdy = 1'b1;
      wait_idle(1'b0);
      checks++;
      if (n_xfer - s_xfer !== 2 || tot !== 8'd3 || chg_v !== 1'b0) begin
         errors++;
         $display("FAIL stall_change: xfer=%0d tot=%0d chg_v=%b, required 2/3/0", n_xfer - s_xfer, tot, chg_v);
      end
      checks++;
      if (n_rej - s_rej !== 1) begin
         errors++;
         $display("FAIL coin_in_change: rej=%0d required 1", n_rej - s_rej);
      end
      m_tot = 3;
   endtask

   task automatic test_sel_err();
      snap();
      select(2, 1'b0);
      checks++;
      if (n_selerr - s_selerr !== 1 || n_d - s_d !== 0 || tot !== 8'd3) begin
         errors++;
         $display("FAIL sel_disabled: sel_err=%0d d=%0d tot=%0d, required 1/0/3", n_selerr - s_selerr, n_d - s_d, tot);
      end
   endtask

   task automatic test_reset_mid_change();
      coin(17);
      chg_rdy = 1'b0;
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b1 || chg_v !== 1'b1 || tot !== 8'd20) begin
         errors++;
         $display("FAIL midreset_setup: busy=%b chg_v=%b tot=%0d, required 1/1/20", busy, chg_v, tot);
      end
      nrst = 1'b0;
      #1;
      checks++;
      if ({d, d_item, chg_v, coin_rej, shrt, sel_err, busy} !== '0 || tot !== 8'd0) begin
         errors++;
         $display("FAIL midreset_async: chg_v=%b busy=%b tot=%0d, required all 0", chg_v, busy, tot);
      end
      @(posedge clk);
      #1;
      nrst = 1'b1;
      chg_rdy = 1'b1;
      tick();
      checks++;
      if (tot !== 8'd0 || busy !== 1'b0 || chg_v !== 1'b0) begin
         errors++;
         $display("FAIL midreset_release: tot=%0d busy=%b chg_v=%b, required 0/0/0", tot, busy, chg_v);
      end
      m_tot = 0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 150; it++) begin
         int op, v, idx, p, e_d, e_rej, e_short, e_sel, e_xfer;
         op = $urandom_range(0, 9);
         e_d = 0; e_rej = 0; e_short = 0; e_sel = 0; e_xfer = 0; idx = 0;
         snap();
         if (op <= 4) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            if (m_tot + v > 255) e_rej = 1;
            else m_tot += v;
            coin(v);
         end else if (op <= 7) begin
            idx = $urandom_range(0, N - 1);
            p = price_tab[idx];
            if (p == 0) e_sel = 1;
            else if (m_tot < p) e_short = 1;
            else begin
               e_d = 1;
               m_tot -= p;
               e_xfer = m_tot / U;
               m_tot = m_tot % U;
            end
            select(idx, 1'b1);
         end else if (op == 8) begin
            e_xfer = m_tot / U;
            m_tot = m_tot % U;
            cancel_req(1'b1);
         end else begin
            for (int i = 0; i < N; i++)
               price_tab[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
            set_prices();
            tick();
         end
         checks++;
         if (n_d - s_d !== e_d || n_rej - s_rej !== e_rej || n_short - s_short !== e_short ||
             n_selerr - s_selerr !== e_sel || n_xfer - s_xfer !== e_xfer) begin
            errors++;
            $display("FAIL rand_events op%0d: d/rej/short/sel_err/xfer got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                     it, n_d - s_d, n_rej - s_rej, n_short - s_short, n_selerr - s_selerr, n_xfer - s_xfer,
                     e_d, e_rej, e_short, e_sel, e_xfer);
         end
         checks++;
         if (tot !== m_tot[W-1:0]) begin
            errors++;
            $display("FAIL rand_tot op%0d: tot=%0d required %0d", it, tot, m_tot);
         end
         if (e_d == 1) begin
            checks++;
            if (last_item !== idx[IW-1:0]) begin
               errors++;
               $display("FAIL rand_item op%0d: d_item=%0d required %0d", it, last_item, idx);
            end
         end
      end
   endtask

   initial begin
      nrst = 1'b0; c = 1'b0; a = '0; sel_v = 1'b0; sel = '0; cancel = 1'b0; chg_rdy = 1'b1;
      price_tab[0] = 25; price_tab[1] = 40; price_tab[2] = 0; price_tab[3] = 255;
      set_prices();
      test_reset();
      test_purchase();
      test_short();
      test_overflow();
      test_stall_cancel();
      test_sel_err();
      test_reset_mid_change();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
